// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with a word RAM and an MMIO
// window holding GPIO, a free-running cycle counter and a timer compare.
// Ports:
//   CLK, RSTn        clock, async active-low reset
//   address_DMEM     word address from the core
//   write_data_DMEM  store data
//   MemWrite         store strobe (commits at posedge CLK)
//   MemRead          load enable
//   data_DMEM        combinational load data (0 when MemRead=0)
//   gpio_in          async external inputs (2-flop synchronized)
//   gpio_out         registered GPIO outputs
//   timer_irq        level IRQ, equal to the sticky timer flag
module dmem_responder #(
  parameter int unsigned         ADDR_W    = 10,
  parameter logic [ADDR_W-1:0]   MMIO_BASE = 10'h3F0,
  parameter int unsigned         GPIO_W    = 8
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [ADDR_W-1:0] address_DMEM,
  input  logic [31:0]       write_data_DMEM,
  input  logic              MemWrite,
  input  logic              MemRead,
  output logic [31:0]       data_DMEM,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [GPIO_W-1:0] gpi_meta;
  logic [GPIO_W-1:0] gpi_sync;
  logic [31:0]       cycle;
  logic [31:0]       timer_cmp;
  logic              flag;

  logic       mmio_sel;
  logic [3:0] offset;
  logic       sel_gpo;
  logic       sel_gpi;
  logic       sel_cyc;
  logic       sel_cmp;
  logic       sel_sts;
  logic       wr_mmio;
  logic       hit;
  logic       clr;
  logic [31:0] rd_mmio;
  logic [31:0] rd_ram;

  assign mmio_sel = address_DMEM[ADDR_W-1:4]
                 == MMIO_BASE[ADDR_W-1:4];
  assign offset   = address_DMEM[3:0];

  assign sel_gpo = offset == 4'd0;
  assign sel_gpi = offset == 4'd1;
  assign sel_cyc = offset == 4'd2;
  assign sel_cmp = offset == 4'd3;
  assign sel_sts = offset == 4'd4;

  assign wr_mmio = MemWrite & mmio_sel;

  // Compare uses the registered values, never the data being written.
  assign hit = cycle == timer_cmp;
  assign clr = wr_mmio & sel_sts & write_data_DMEM[0];

  assign timer_irq = flag;

  // RAM keeps its contents across reset; MMIO addresses shadow it.
  always_ff @(posedge CLK) begin
    if (MemWrite && !mmio_sel)
      mem[address_DMEM] <= write_data_DMEM;
  end

  assign rd_ram = mem[address_DMEM];

  always_comb begin
    rd_mmio = '0;
    unique case (1'b1)
      sel_gpo: rd_mmio[GPIO_W-1:0] = gpio_out;
      sel_gpi: rd_mmio[GPIO_W-1:0] = gpi_sync;
      sel_cyc: rd_mmio = cycle;
      sel_cmp: rd_mmio = timer_cmp;
      sel_sts: rd_mmio[0] = flag;
      default: rd_mmio = '0;
    endcase
  end

  always_comb begin
    data_DMEM = '0;
    if (MemRead)
      data_DMEM = mmio_sel ? rd_mmio : rd_ram;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      gpio_out  <= '0;
      gpi_meta  <= '0;
      gpi_sync  <= '0;
      cycle     <= '0;
      timer_cmp <= 32'hFFFF_FFFF;
      flag      <= 1'b0;
    end else begin
      gpi_meta <= gpio_in;
      gpi_sync <= gpi_meta;
      if (wr_mmio && sel_gpo)
        gpio_out <= write_data_DMEM[GPIO_W-1:0];
      // A counter load beats the increment.
      if (wr_mmio && sel_cyc)
        cycle <= write_data_DMEM;
      else
        cycle <= cycle + 32'd1;
      if (wr_mmio && sel_cmp)
        timer_cmp <= write_data_DMEM;
      // Set beats a simultaneous W1C.
      flag <= hit | (flag & ~clr);
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: table vectors, corner sequences and random
// stimulus for dmem_responder, checked against a behavioural model.
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [9:0]  address_DMEM = '0;
  logic [31:0] write_data_DMEM = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] data_DMEM;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  dmem_responder dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .address_DMEM(address_DMEM),
    .write_data_DMEM(write_data_DMEM),
    .MemWrite(MemWrite),
    .MemRead(MemRead),
    .data_DMEM(data_DMEM),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .timer_irq(timer_irq)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [31:0] m_ram [int];
  logic [7:0]  m_gpo;
  logic [7:0]  hist [$];
  logic [31:0] m_cyc;
  logic [31:0] m_cmp;
  logic        m_flag;

  logic [7:0]  pin = '0;
  logic [31:0] cap_data;
  logic [7:0]  cap_gpo;
  logic        cap_irq;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] wd;
    logic        we;
    logic        re;
    logic [7:0]  gpi;
    logic [31:0] xd;
    logic [7:0]  xg;
    logic        xi;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_gpo  = '0;
    hist   = '{8'h00, 8'h00};
    m_cyc  = '0;
    m_cmp  = 32'hFFFF_FFFF;
    m_flag = 1'b0;
  endtask

  task automatic model_read(input logic [9:0] a, input logic re,
                            output logic [31:0] v, output bit known);
    known = 1;
    v = '0;
    if (!re) return;
    if (a[9:4] == 6'h3F) begin
      case (a[3:0])
        4'd0: v = {24'h0, m_gpo};
        4'd1: v = {24'h0, hist[1]};
        4'd2: v = m_cyc;
        4'd3: v = m_cmp;
        4'd4: v = {31'h0, m_flag};
        default: v = '0;
      endcase
    end else if (m_ram.exists(int'(a))) begin
      v = m_ram[int'(a)];
    end else begin
      known = 0;
    end
  endtask

  task automatic model_edge(input logic [9:0] a, input logic [31:0] wd,
                            input logic we, input logic [7:0] g);
    bit mm;
    bit set;
    mm  = a[9:4] == 6'h3F;
    set = m_cyc == m_cmp;
    if (we && !mm) m_ram[int'(a)] = wd;
    if (we && mm && a[3:0] == 4'd0) m_gpo = wd[7:0];
    if (we && mm && a[3:0] == 4'd4 && wd[0]) m_flag = 1'b0;
    if (set) m_flag = 1'b1;
    if (we && mm && a[3:0] == 4'd2) m_cyc = wd;
    else m_cyc = m_cyc + 32'd1;
    if (we && mm && a[3:0] == 4'd3) m_cmp = wd;
    hist.push_front(g);
    void'(hist.pop_back());
  endtask

  // One bus cycle: drive after the edge, sample at negedge, then clock.
  task automatic step(input logic [9:0] a, input logic [31:0] wd,
                      input logic we, input logic re);
    logic [31:0] ev;
    bit known;
    address_DMEM = a;
    write_data_DMEM = wd;
    MemWrite = we;
    MemRead = re;
    gpio_in = pin;
    @(negedge CLK);
    cap_data = data_DMEM;
    cap_gpo = gpio_out;
    cap_irq = timer_irq;
    model_read(a, re, ev, known);
    if (known) chk("rdata", cap_data, ev);
    chk("gpio_out", 32'(cap_gpo), 32'(m_gpo));
    chk("irq", 32'(cap_irq), 32'(m_flag));
    @(posedge CLK);
    model_edge(a, wd, we, pin);
    #1;
  endtask

  task automatic mid_reset();
    #2;
    RSTn = 1'b0;
    MemWrite = 1'b0;
    MemRead = 1'b1;
    address_DMEM = 10'h3F2;
    #1;
    chk("rst gpio_out", 32'(gpio_out), 32'h0);
    chk("rst irq", 32'(timer_irq), 32'h0);
    chk("rst cycle", data_DMEM, 32'h0);
    model_reset();
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
  endtask

  initial begin
    logic [9:0] ra [8];
    logic [9:0] a;
    logic [31:0] wd;
    tbl[0]  = '{10'h3F2, 32'h0,        1'b0, 1'b1, 8'h00, 32'h0,        8'h00, 1'b0};
    tbl[1]  = '{10'h005, 32'hDEADBEEF, 1'b1, 1'b0, 8'h00, 32'h0,        8'h00, 1'b0};
    tbl[2]  = '{10'h005, 32'h0,        1'b0, 1'b1, 8'h00, 32'hDEADBEEF, 8'h00, 1'b0};
    tbl[3]  = '{10'h005, 32'h0,        1'b0, 1'b0, 8'h00, 32'h0,        8'h00, 1'b0};
    tbl[4]  = '{10'h007, 32'h1,        1'b1, 1'b0, 8'h00, 32'h0,        8'h00, 1'b0};
    tbl[5]  = '{10'h007, 32'h2,        1'b1, 1'b1, 8'h00, 32'h1,        8'h00, 1'b0};
    tbl[6]  = '{10'h007, 32'h0,        1'b0, 1'b1, 8'h00, 32'h2,        8'h00, 1'b0};
    tbl[7]  = '{10'h3F0, 32'h1A5,      1'b1, 1'b0, 8'h00, 32'h0,        8'h00, 1'b0};
    tbl[8]  = '{10'h3F0, 32'h0,        1'b0, 1'b1, 8'h00, 32'hA5,       8'hA5, 1'b0};
    tbl[9]  = '{10'h3F8, 32'h1234,     1'b1, 1'b1, 8'h00, 32'h0,        8'hA5, 1'b0};
    tbl[10] = '{10'h3F2, 32'h0,        1'b0, 1'b1, 8'h00, 32'd10,       8'hA5, 1'b0};
    tbl[11] = '{10'h3F8, 32'h0,        1'b0, 1'b1, 8'h00, 32'h0,        8'hA5, 1'b0};
    tbl[12] = '{10'h3F1, 32'h0,        1'b0, 1'b1, 8'h3C, 32'h0,        8'hA5, 1'b0};
    tbl[13] = '{10'h3F1, 32'h0,        1'b0, 1'b1, 8'h3C, 32'h0,        8'hA5, 1'b0};
    tbl[14] = '{10'h3F1, 32'h0,        1'b0, 1'b1, 8'h3C, 32'h3C,       8'hA5, 1'b0};
    tbl[15] = '{10'h3F2, 32'hFFFFFFFE, 1'b1, 1'b1, 8'h3C, 32'd15,       8'hA5, 1'b0};
    tbl[16] = '{10'h3F2, 32'h0,        1'b0, 1'b1, 8'h3C, 32'hFFFFFFFE, 8'hA5, 1'b0};
    tbl[17] = '{10'h3F2, 32'h0,        1'b0, 1'b1, 8'h3C, 32'hFFFFFFFF, 8'hA5, 1'b0};
    tbl[18] = '{10'h3F2, 32'h0,        1'b0, 1'b1, 8'h3C, 32'h0,        8'hA5, 1'b1};
    tbl[19] = '{10'h3F4, 32'h0,        1'b0, 1'b1, 8'h3C, 32'h1,        8'hA5, 1'b1};
    tbl[20] = '{10'h3F4, 32'h0,        1'b1, 1'b0, 8'h3C, 32'h0,        8'hA5, 1'b1};
    tbl[21] = '{10'h3F4, 32'h1,        1'b1, 1'b1, 8'h3C, 32'h1,        8'hA5, 1'b1};
    tbl[22] = '{10'h3F4, 32'h0,        1'b0, 1'b1, 8'h3C, 32'h0,        8'hA5, 1'b0};

    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset gpio_out", 32'(gpio_out), 32'h0);
    chk("reset irq", 32'(timer_irq), 32'h0);
    RSTn = 1'b1;

    for (int i = 0; i < 23; i++) begin
      pin = tbl[i].gpi;
      step(tbl[i].a, tbl[i].wd, tbl[i].we, tbl[i].re);
      chk($sformatf("vec%0d data", i), cap_data, tbl[i].xd);
      chk($sformatf("vec%0d gpio", i), 32'(cap_gpo), 32'(tbl[i].xg));
      chk($sformatf("vec%0d irq", i), 32'(cap_irq), 32'(tbl[i].xi));
    end

    // Timer match at 20 after reloading the counter.
    step(10'h3F3, 32'd20, 1'b1, 1'b0);
    step(10'h3F2, 32'd0, 1'b1, 1'b0);
    for (int k = 0; k <= 20; k++) step(10'h3F2, 32'h0, 1'b0, 1'b1);
    chk("cycle at match", cap_data, 32'd20);
    chk("irq before match edge", 32'(cap_irq), 32'h0);
    step(10'h3F4, 32'h0, 1'b0, 1'b1);
    chk("status after match", cap_data, 32'h1);
    chk("irq after match", 32'(cap_irq), 32'h1);
    step(10'h3F4, 32'h0, 1'b1, 1'b0);
    step(10'h3F4, 32'h0, 1'b0, 1'b1);
    chk("irq after w0", 32'(cap_irq), 32'h1);
    step(10'h3F4, 32'h1, 1'b1, 1'b0);
    step(10'h3F4, 32'h0, 1'b0, 1'b1);
    chk("irq after w1c", 32'(cap_irq), 32'h0);
    chk("status after w1c", cap_data, 32'h0);

    // W1C landing on the same edge as a match: set must win.
    step(10'h3F3, 32'd103, 1'b1, 1'b0);
    step(10'h3F2, 32'd100, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(10'h3F2, 32'h0, 1'b0, 1'b1);
    step(10'h3F4, 32'h1, 1'b1, 1'b1);
    step(10'h3F4, 32'h0, 1'b0, 1'b1);
    chk("set beats w1c", 32'(cap_irq), 32'h1);

    // Async reset mid-count; RAM must survive it.
    mid_reset();
    step(10'h005, 32'h0, 1'b0, 1'b1);
    chk("ram kept over reset", cap_data, 32'hDEADBEEF);
    step(10'h3F3, 32'h0, 1'b0, 1'b1);
    chk("cmp after reset", cap_data, 32'hFFFFFFFF);

    // Random traffic against the model.
    ra = '{10'h005, 10'h007, 10'h010, 10'h3EF,
           10'h200, 10'h1FF, 10'h000, 10'h0F0};
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0)
        a = ra[$urandom_range(0, 7)];
      else
        a = 10'h3F0 + 10'($urandom_range(0, 15));
      wd = $urandom;
      if (a == 10'h3F3 && $urandom_range(0, 1) == 1)
        wd = m_cyc + 32'($urandom_range(1, 4));
      if (a == 10'h3F2 && $urandom_range(0, 3) == 0)
        wd = 32'hFFFF_FFFD;
      pin = 8'($urandom);
      step(a, wd, 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
